// File: rtl/regfile_2r2w.sv
// Two-read / two-write register file with registered, write-first reads
// and a sequential clear engine that sweeps every entry to CLR_VAL.
// While the clear engine runs, writes are dropped and reads keep working.
module regfile_2r2w #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 5,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en1,
    input  logic              w_en2,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic [ADDR_W-1:0] w_addr2,
    input  logic [DATA_W-1:0] w_data1,
    input  logic [DATA_W-1:0] w_data2,
    input  logic [ADDR_W-1:0] r_addr1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic [DATA_W-1:0] r_data1,
    output logic [DATA_W-1:0] r_data2,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_conflict,
    output logic              fsm_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                we1, we2;
    logic [DATA_W-1:0]   rd1_nxt, rd2_nxt;

    // Clear engine owns the array while active; user writes are gated off.
    assign busy      = (state == CLEAR);
    assign fsm_state = (state == CLEAR);
    assign we1       = w_en1 && !busy;
    assign we2       = w_en2 && !busy;

    // Clear FSM state and sweep counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear FSM next state: start on request, leave after the last entry.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Array update: clear sweep, or user writes with port 2 written last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[clr_cnt] <= CLR_VAL;
        end else begin
            if (we1) mem[w_addr1] <= w_data1;
            if (we2) mem[w_addr2] <= w_data2;
        end
    end

    // Read port 1 next value with write-first forwarding.
    always_comb begin
        rd1_nxt = mem[r_addr1];
        if (busy) begin
            if (clr_cnt == r_addr1) rd1_nxt = CLR_VAL;
        end else begin
            if (we1 && (w_addr1 == r_addr1)) rd1_nxt = w_data1;
            if (we2 && (w_addr2 == r_addr1)) rd1_nxt = w_data2;
        end
    end

    // Read port 2 next value with write-first forwarding.
    always_comb begin
        rd2_nxt = mem[r_addr2];
        if (busy) begin
            if (clr_cnt == r_addr2) rd2_nxt = CLR_VAL;
        end else begin
            if (we1 && (w_addr1 == r_addr2)) rd2_nxt = w_data1;
            if (we2 && (w_addr2 == r_addr2)) rd2_nxt = w_data2;
        end
    end

    // Registered read data and the one-cycle same-address conflict flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data1     <= '0;
            r_data2     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            r_data1     <= rd1_nxt;
            r_data2     <= rd2_nxt;
            wr_conflict <= we1 && we2 && (w_addr1 == w_addr2);
        end
    end

endmodule

// File: tb/tb_regfile_2r2w.sv
// Bench for regfile_2r2w: a default-size instance (CLR_VAL=0xAA) driven from
// a vector table, random traffic and clear/reset sequences, plus a small
// ADDR_W=3 / DATA_W=16 instance exercised by hand.
module tb_regfile_2r2w;

    localparam int         AW   = 5;
    localparam int         DW   = 8;
    localparam logic [7:0] CLRA = 8'hAA;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- instance A (default size) ----------------
    logic          rst, clr_req, w_en1, w_en2, busy, wr_conflict, fsm_state;
    logic [AW-1:0] w_addr1, w_addr2, r_addr1, r_addr2;
    logic [DW-1:0] w_data1, w_data2, r_data1, r_data2;

    regfile_2r2w #(.DATA_W(DW), .ADDR_W(AW), .CLR_VAL(CLRA)) dut_a (
        .clk(clk), .rst(rst),
        .w_en1(w_en1), .w_en2(w_en2),
        .w_addr1(w_addr1), .w_addr2(w_addr2),
        .w_data1(w_data1), .w_data2(w_data2),
        .r_addr1(r_addr1), .r_addr2(r_addr2),
        .r_data1(r_data1), .r_data2(r_data2),
        .clr_req(clr_req), .busy(busy),
        .wr_conflict(wr_conflict), .fsm_state(fsm_state)
    );

    // ---------------- instance B (ADDR_W=3, DATA_W=16) ----------------
    logic        b_rst, b_clr_req, b_w_en1, b_w_en2, b_busy, b_wr_conflict, b_fsm_state;
    logic [2:0]  b_w_addr1, b_w_addr2, b_r_addr1, b_r_addr2;
    logic [15:0] b_w_data1, b_w_data2, b_r_data1, b_r_data2;

    regfile_2r2w #(.DATA_W(16), .ADDR_W(3), .CLR_VAL(16'h0F0F)) dut_b (
        .clk(clk), .rst(b_rst),
        .w_en1(b_w_en1), .w_en2(b_w_en2),
        .w_addr1(b_w_addr1), .w_addr2(b_w_addr2),
        .w_data1(b_w_data1), .w_data2(b_w_data2),
        .r_addr1(b_r_addr1), .r_addr2(b_r_addr2),
        .r_data1(b_r_data1), .r_data2(b_r_data2),
        .clr_req(b_clr_req), .busy(b_busy),
        .wr_conflict(b_wr_conflict), .fsm_state(b_fsm_state)
    );

    // ---------------- vectors, model, scoreboard ----------------
    typedef struct {
        logic          rst;
        logic          clr;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        logic          exp_conf;
        logic          exp_busy;
    } vec_t;

    vec_t              tbl[11];
    logic [DW-1:0]     mdl [32];
    logic [2*DW+1:0]   exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                                input logic we2, input logic [AW-1:0] wa2, input logic [DW-1:0] wd2,
                                input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                                input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic ec);
        vec_t v;
        v.rst = 1'b0; v.clr = 1'b0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.we2 = we2; v.wa2 = wa2; v.wd2 = wd2;
        v.ra1 = ra1; v.ra2 = ra2;
        v.exp1 = e1; v.exp2 = e2; v.exp_conf = ec; v.exp_busy = 1'b0;
        return v;
    endfunction

    // Expected read value from the model for an idle-state cycle (write-first).
    function automatic logic [DW-1:0] pred(input vec_t v, input logic [AW-1:0] ra);
        if (v.we2 && v.wa2 == ra) return v.wd2;
        if (v.we1 && v.wa1 == ra) return v.wd1;
        return mdl[ra];
    endfunction

    task automatic mdl_write(input vec_t v);
        if (v.we1) mdl[v.wa1] = v.wd1;
        if (v.we2) mdl[v.wa2] = v.wd2;
    endtask

    task automatic mdl_fill(input logic [DW-1:0] val);
        for (int i = 0; i < 32; i++) mdl[i] = val;
    endtask

    // Driver: apply one vector, push its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        logic [2*DW+1:0] e;
        rst = v.rst; clr_req = v.clr;
        w_en1 = v.we1; w_addr1 = v.wa1; w_data1 = v.wd1;
        w_en2 = v.we2; w_addr2 = v.wa2; w_data2 = v.wd2;
        r_addr1 = v.ra1; r_addr2 = v.ra2;
        exp_q.push_back({v.exp1, v.exp2, v.exp_conf, v.exp_busy});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " r_data1"}, 32'(r_data1), 32'(e[2*DW+1:DW+2]));
        check({tag, " r_data2"}, 32'(r_data2), 32'(e[DW+1:2]));
        check({tag, " wr_conflict"}, 32'(wr_conflict), 32'(e[1]));
        check({tag, " busy"}, 32'(busy), 32'(e[0]));
        check({tag, " fsm_state"}, 32'(fsm_state), 32'(e[0]));
    endtask

    task automatic b_tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t v;
        int   cnt;

        rst = 1'b1; clr_req = 1'b0; w_en1 = 1'b0; w_en2 = 1'b0;
        w_addr1 = '0; w_addr2 = '0; w_data1 = '0; w_data2 = '0;
        r_addr1 = '0; r_addr2 = '0;
        b_rst = 1'b1; b_clr_req = 1'b0; b_w_en1 = 1'b0; b_w_en2 = 1'b0;
        b_w_addr1 = '0; b_w_addr2 = '0; b_w_data1 = '0; b_w_data2 = '0;
        b_r_addr1 = '0; b_r_addr2 = '0;

        // Hand-derived vectors starting from an all-zero array.
        tbl[0]  = mk(1'b1, 5'd9,  8'd45,  1'b1, 5'd13, 8'd67,  5'd0,  5'd0,  8'd0,   8'd0,   1'b0);
        tbl[1]  = mk(1'b0, 5'd0,  8'd0,   1'b0, 5'd0,  8'd0,   5'd13, 5'd9,  8'd67,  8'd45,  1'b0);
        tbl[2]  = mk(1'b1, 5'd20, 8'd11,  1'b1, 5'd20, 8'd22,  5'd20, 5'd9,  8'd22,  8'd45,  1'b1);
        tbl[3]  = mk(1'b0, 5'd0,  8'd0,   1'b0, 5'd0,  8'd0,   5'd20, 5'd20, 8'd22,  8'd22,  1'b0);
        tbl[4]  = mk(1'b1, 5'd5,  8'd99,  1'b0, 5'd0,  8'd0,   5'd5,  5'd13, 8'd99,  8'd67,  1'b0);
        tbl[5]  = mk(1'b1, 5'd6,  8'd33,  1'b1, 5'd5,  8'd77,  5'd6,  5'd5,  8'd33,  8'd77,  1'b0);
        tbl[6]  = mk(1'b1, 5'd6,  8'd1,   1'b1, 5'd6,  8'd2,   5'd6,  5'd5,  8'd2,   8'd77,  1'b1);
        tbl[7]  = mk(1'b1, 5'd6,  8'd3,   1'b1, 5'd6,  8'd4,   5'd6,  5'd5,  8'd4,   8'd77,  1'b1);
        tbl[8]  = mk(1'b0, 5'd0,  8'd0,   1'b0, 5'd0,  8'd0,   5'd6,  5'd0,  8'd4,   8'd0,   1'b0);
        tbl[9]  = mk(1'b1, 5'd31, 8'hFF,  1'b1, 5'd0,  8'h80,  5'd0,  5'd31, 8'h80,  8'hFF,  1'b0);
        tbl[10] = mk(1'b0, 5'd0,  8'h11,  1'b1, 5'd0,  8'h12,  5'd0,  5'd31, 8'h12,  8'hFF,  1'b0);

        // Reset: two edges with rst held, everything must read zero.
        v = mk(1'b1, 5'd1, 8'h5C, 1'b1, 5'd1, 8'h5D, 5'd1, 5'd2, 8'd0, 8'd0, 1'b0);
        v.rst = 1'b1; v.clr = 1'b1;
        step(v, "reset0");
        step(v, "reset1");
        mdl_fill(8'd0);

        // Table-driven directed vectors.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
            mdl_write(tbl[i]);
        end

        // Random idle traffic checked against the model.
        for (int i = 0; i < 24; i++) begin
            v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 8'd0, 8'd0, 1'b0);
            if ($urandom_range(0, 3) == 0) v.wa2 = v.wa1;
            if ($urandom_range(0, 1) == 0) v.ra1 = v.wa1;
            if ($urandom_range(0, 1) == 0) v.ra2 = v.wa2;
            v.exp1     = pred(v, v.ra1);
            v.exp2     = pred(v, v.ra2);
            v.exp_conf = v.we1 && v.we2 && (v.wa1 == v.wa2);
            step(v, $sformatf("rnd%0d", i));
            mdl_write(v);
        end

        // Clear request together with a write: the write lands first.
        v = mk(1'b1, 5'd3, 8'h55, 1'b0, 5'd0, 8'd0, 5'd3, 5'd4, 8'h55, 8'd0, 1'b0);
        v.exp2 = mdl[4];
        v.clr = 1'b1; v.exp_busy = 1'b1;
        step(v, "clr_start");
        mdl_write(v);

        // Sweep: busy for exactly 32 cycles, writes and re-requests ignored.
        for (int j = 1; j <= 32; j++) begin
            v = mk(1'b1, 5'd0, 8'h11, 1'b1, 5'd0, 8'h22, 5'(j - 1), 5'd31, CLRA, 8'd0, 1'b0);
            v.clr      = 1'b1;
            v.exp2     = (j == 32) ? CLRA : mdl[31];
            v.exp_busy = (j < 32);
            step(v, $sformatf("clr%0d", j));
        end
        mdl_fill(CLRA);
        for (int i = 0; i < 16; i++) begin
            v = mk(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0, 5'(2 * i), 5'(2 * i + 1), CLRA, CLRA, 1'b0);
            step(v, $sformatf("clr_rd%0d", i));
        end

        // Seed a few non-clear values, then abort a clear with reset.
        v = mk(1'b1, 5'd7, 8'h3C, 1'b1, 5'd31, 8'hC3, 5'd7, 5'd31, 8'h3C, 8'hC3, 1'b0);
        step(v, "seed");
        mdl_write(v);
        v = mk(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0, 5'd7, 5'd31, 8'h3C, 8'hC3, 1'b0);
        v.clr = 1'b1; v.exp_busy = 1'b1;
        step(v, "abort_start");
        for (int j = 1; j < 10; j++) begin
            v = mk(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0, 5'd7, 5'd31, 8'd0, 8'd0, 1'b0);
            v.exp1     = (j >= 8) ? CLRA : 8'h3C;
            v.exp2     = 8'hC3;
            v.exp_busy = 1'b1;
            step(v, $sformatf("abort%0d", j));
        end
        v = mk(1'b1, 5'd2, 8'h77, 1'b0, 5'd0, 8'd0, 5'd7, 5'd31, 8'd0, 8'd0, 1'b0);
        v.rst = 1'b1;
        step(v, "abort_rst");
        mdl_fill(8'd0);
        for (int i = 0; i < 16; i++) begin
            v = mk(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0, 5'(2 * i), 5'(2 * i + 1), 8'd0, 8'd0, 1'b0);
            step(v, $sformatf("rst_rd%0d", i));
        end
        v = mk(1'b1, 5'd31, 8'h5A, 1'b0, 5'd0, 8'd0, 5'd31, 5'd0, 8'h5A, 8'd0, 1'b0);
        step(v, "post_rst_wr");
        v = mk(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0, 5'd30, 5'd31, 8'd0, 8'h5A, 1'b0);
        step(v, "post_rst_rd");

        // Small instance: reset, round trip of 0xBEEF at addr 7, 8-cycle clear.
        b_tick();
        check("b_reset r_data1", 32'(b_r_data1), 32'h0);
        check("b_reset busy", 32'(b_busy), 32'h0);
        b_rst = 1'b0;
        b_w_en1 = 1'b1; b_w_addr1 = 3'd7; b_w_data1 = 16'hBEEF; b_r_addr1 = 3'd7;
        b_tick();
        check("b_wr_first r_data1", 32'(b_r_data1), 32'hBEEF);
        b_w_en1 = 1'b0; b_r_addr2 = 3'd7; b_r_addr1 = 3'd0;
        b_tick();
        check("b_rd r_data2", 32'(b_r_data2), 32'hBEEF);
        check("b_rd r_data1", 32'(b_r_data1), 32'h0);
        b_clr_req = 1'b1;
        b_tick();
        b_clr_req = 1'b0;
        check("b_clr busy", 32'(b_busy), 32'h1);
        check("b_clr fsm_state", 32'(b_fsm_state), 32'h1);
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 20) begin
            cnt++;
            b_tick();
        end
        check("b_clr cycles", 32'(cnt), 32'd8);
        b_r_addr1 = 3'd7; b_r_addr2 = 3'd0;
        b_tick();
        check("b_clr r_data1", 32'(b_r_data1), 32'h0F0F);
        check("b_clr r_data2", 32'(b_r_data2), 32'h0F0F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
